// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared constants and types for the Y86-64 pipeline control
//               unit. It holds the instruction codes the hazard logic looks
//               at, the pipeline status codes and the run-state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Instruction codes inspected by the hazard logic
    localparam logic [3:0] c_ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] c_ICODE_OPQ    = 4'h6;
    localparam logic [3:0] c_ICODE_JXX    = 4'h7;
    localparam logic [3:0] c_ICODE_RET    = 4'h9;
    localparam logic [3:0] c_ICODE_POPQ   = 4'hB;

    // Pipeline status codes; TMO is produced internally by the watchdog
    localparam logic [3:0] c_STAT_AOK = 4'd1;
    localparam logic [3:0] c_STAT_HLT = 4'd2;
    localparam logic [3:0] c_STAT_ADR = 4'd3;
    localparam logic [3:0] c_STAT_INS = 4'd4;
    localparam logic [3:0] c_STAT_TMO = 4'd5;

    // Register ID meaning "no register"
    localparam logic [3:0] c_REG_NONE = 4'hF;

    // Run-state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Bundle between the pipeline datapath and its control unit.
//               The datapath (master) presents stage-register fields and
//               receives per-stage stall/bubble and condition-code enable;
//               the control unit (slave) sees the opposite directions.
// Ports       : D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode,
//               m_stat, W_stat (datapath -> control);
//               F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
//               set_cc (control -> datapath)
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;

    logic [3:0] D_icode;
    logic [3:0] d_srcA;
    logic [3:0] d_srcB;
    logic [3:0] E_icode;
    logic [3:0] E_dstM;
    logic       e_Cnd;
    logic [3:0] M_icode;
    logic [3:0] m_stat;
    logic [3:0] W_stat;

    logic       F_stall;
    logic       D_stall;
    logic       D_bubble;
    logic       E_bubble;
    logic       M_bubble;
    logic       W_stall;
    logic       set_cc;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               set_cc
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               set_cc
    );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_detect
// Description : Purely combinational hazard classifier. Looks at the
//               stage-register fields and flags load/use, ret in flight,
//               branch mispredict and exceptions in memory/write-back.
// Ports       : D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, e_Cnd_i,
//               M_icode_i, m_stat_i, W_stat_i (in);
//               load_use_o, ret_haz_o, mispred_o, excM_o, excW_o (out)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] D_icode_i,
    input  logic [3:0] d_srcA_i,
    input  logic [3:0] d_srcB_i,
    input  logic [3:0] E_icode_i,
    input  logic [3:0] E_dstM_i,
    input  logic       e_Cnd_i,
    input  logic [3:0] M_icode_i,
    input  logic [3:0] m_stat_i,
    input  logic [3:0] W_stat_i,
    output logic       load_use_o,
    output logic       ret_haz_o,
    output logic       mispred_o,
    output logic       excM_o,
    output logic       excW_o
);

    logic e_is_load;

    // Only mrmovq and popq write a register from memory in the execute slot
    assign e_is_load  = (E_icode_i == c_ICODE_MRMOVQ) || (E_icode_i == c_ICODE_POPQ);

    // A load that targets REG_NONE never conflicts, even if a source is also
    // REG_NONE
    assign load_use_o = e_is_load && (E_dstM_i != c_REG_NONE) &&
                        ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));

    assign ret_haz_o  = (D_icode_i == c_ICODE_RET) ||
                        (E_icode_i == c_ICODE_RET) ||
                        (M_icode_i == c_ICODE_RET);

    // Branches are predicted taken, so a not-taken jXX in execute mispredicted
    assign mispred_o  = (E_icode_i == c_ICODE_JXX) && !e_Cnd_i;

    assign excM_o     = (m_stat_i != c_STAT_AOK);
    assign excW_o     = (W_stat_i != c_STAT_AOK);

endmodule : pipe_hazard_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline control unit for the five-stage Y86-64 pipeline.
//               Turns hazard flags into per-stage stall/bubble controls and
//               the condition-code enable, and sequences the run state
//               IDLE -> RUN -> HALTED (exception or watchdog timeout).
// Ports       : clk, rst, start (in); pif (pipe_hazard_ctrl_if.slave);
//               running, halted, halt_stat[3:0], cyc_cnt[CNT_W-1:0] (out);
//               lu_cnt, ret_cnt, mp_cnt [CNT_W-1:0] (out, perf build only)
// Parameters  : MAX_CYCLES - watchdog limit on RUN cycles, 0 disables it
//               CNT_W      - width of the cycle and perf counters
// Macros      : PIPE_HAZARD_PERF_EN - adds saturating hazard perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_CYCLES = 0,
    parameter int CNT_W      = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    pipe_hazard_ctrl_if.slave pif,
    output logic             running,
    output logic             halted,
    output logic [3:0]       halt_stat,
    output logic [CNT_W-1:0] cyc_cnt
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] mp_cnt
`endif
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam bit               c_WD_EN   = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] c_WD_LAST = (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);

    state_t           state_q;
    logic             running_q;
    logic             halted_q;
    logic [3:0]       halt_stat_q;
    logic [CNT_W-1:0] cyc_cnt_q;
    logic [CNT_W-1:0] cyc_cnt_d;

    logic load_use;
    logic ret_haz;
    logic mispred;
    logic excM;
    logic excW;
    logic wd_hit;
    logic run_entry;

    pipe_hazard_detect u_detect (
        .D_icode_i  (pif.D_icode),
        .d_srcA_i   (pif.d_srcA),
        .d_srcB_i   (pif.d_srcB),
        .E_icode_i  (pif.E_icode),
        .E_dstM_i   (pif.E_dstM),
        .e_Cnd_i    (pif.e_Cnd),
        .M_icode_i  (pif.M_icode),
        .m_stat_i   (pif.m_stat),
        .W_stat_i   (pif.W_stat),
        .load_use_o (load_use),
        .ret_haz_o  (ret_haz),
        .mispred_o  (mispred),
        .excM_o     (excM),
        .excW_o     (excW)
    );

    assign cyc_cnt_d = (cyc_cnt_q == c_CNT_MAX) ? cyc_cnt_q : (cyc_cnt_q + c_CNT_ONE);
    assign wd_hit    = c_WD_EN && (cyc_cnt_q == c_WD_LAST);
    assign run_entry = (state_q == ST_IDLE) && start;

    // ------------------------------------------------------------------
    // Run-state sequencer with registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            halt_stat_q <= 4'd0;
            cyc_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                        cyc_cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    cyc_cnt_q <= cyc_cnt_d;
                    // A real write-back fault outranks the watchdog
                    if (excW) begin
                        state_q     <= ST_HALTED;
                        running_q   <= 1'b0;
                        halted_q    <= 1'b1;
                        halt_stat_q <= pif.W_stat;
                    end else if (wd_hit) begin
                        state_q     <= ST_HALTED;
                        running_q   <= 1'b0;
                        halted_q    <= 1'b1;
                        halt_stat_q <= c_STAT_TMO;
                    end
                end
                ST_HALTED: begin
                    // Sticky until reset; start is ignored here
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stall/bubble muxing: outside RUN the pipe is frozen with nops
    // injected downstream so nothing retires.
    // ------------------------------------------------------------------
    always_comb begin
        pif.F_stall  = 1'b1;
        pif.D_stall  = 1'b1;
        pif.D_bubble = 1'b0;
        pif.E_bubble = 1'b1;
        pif.M_bubble = 1'b1;
        pif.W_stall  = 1'b1;
        pif.set_cc   = 1'b0;
        if (state_q == ST_RUN) begin
            pif.F_stall  = load_use | ret_haz;
            pif.D_stall  = load_use;
            // Stall wins over bubble in decode
            pif.D_bubble = !load_use & (mispred | ret_haz);
            pif.E_bubble = mispred | load_use;
            pif.M_bubble = excM | excW;
            pif.W_stall  = excW;
            pif.set_cc   = (pif.E_icode == c_ICODE_OPQ) & !excM & !excW;
        end
    end

    assign running   = running_q;
    assign halted    = halted_q;
    assign halt_stat = halt_stat_q;
    assign cyc_cnt   = cyc_cnt_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] lu_cnt_q;
    logic [CNT_W-1:0] ret_cnt_q;
    logic [CNT_W-1:0] mp_cnt_q;
    logic             in_run;

    assign in_run = (state_q == ST_RUN);

    // Saturating hazard counters; the ret counter only counts cycles where
    // the ret bubble actually took effect (not masked by a load/use stall)
    always_ff @(posedge clk) begin
        if (rst || run_entry) begin
            lu_cnt_q  <= '0;
            ret_cnt_q <= '0;
            mp_cnt_q  <= '0;
        end else if (in_run) begin
            if (load_use && (lu_cnt_q != c_CNT_MAX)) begin
                lu_cnt_q <= lu_cnt_q + c_CNT_ONE;
            end
            if (ret_haz && !load_use && (ret_cnt_q != c_CNT_MAX)) begin
                ret_cnt_q <= ret_cnt_q + c_CNT_ONE;
            end
            if (mispred && (mp_cnt_q != c_CNT_MAX)) begin
                mp_cnt_q <= mp_cnt_q + c_CNT_ONE;
            end
        end
    end

    assign lu_cnt  = lu_cnt_q;
    assign ret_cnt = ret_cnt_q;
    assign mp_cnt  = mp_cnt_q;
`else
    // RUN entry only matters to the perf counters
    logic unused_run_entry;
    assign unused_run_entry = run_entry;
`endif

endmodule : pipe_hazard_ctrl
`default_nettype wire
